avalon_st_packet_fifo: RTL

AVALON_ST_PACKET_FIFO -- requirements
Module: avalon_st_packet_fifo

---
 rtl/avalon_st_packet_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_mem.sv | 23 ++
 rtl/avalon_st_packet_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/avalon_st_packet_fifo_pkg.sv
// Shared definitions for the Avalon-ST packet FIFO: CSR address map and beat layout.
// Beat layout is {data, empty, sop, eop}; the top re-declares it at its own DATA_BYTES.
package avalon_st_packet_fifo_pkg;

  localparam logic [1:0] CSR_OCCUPANCY = 2'd0;
  localparam logic [1:0] CSR_HIGHWATER = 2'd1;
  localparam logic [1:0] CSR_PKT_COUNT = 2'd2;
  localparam logic [1:0] CSR_FRAME_ERR = 2'd3;

  localparam int BEAT_DATA_BYTES = 8;

  typedef struct packed {
    logic [BEAT_DATA_BYTES*8-1:0]         data;
    logic [$clog2(BEAT_DATA_BYTES)-1:0]   empty;
    logic                                 sop;
    logic                                 eop;
  } beat_t;

  function automatic int beat_width(input int data_bytes);
    return data_bytes*8 + $clog2(data_bytes) + 2;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// No reset on the array; validity is tracked by the pointers in the top level.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/avalon_st_packet_fifo.sv
// Avalon-ST packet FIFO with first-word fall-through output and an Avalon-MM
// status block (occupancy, high-water, packet count, framing-error count).
module avalon_st_packet_fifo
  import avalon_st_packet_fifo_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BYTES*8-1:0]       stream_in_data,
  input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
  input  logic                          stream_in_valid,
  input  logic                          stream_in_startofpacket,
  input  logic                          stream_in_endofpacket,
  output logic                          stream_in_ready,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(DATA_BYTES);
  localparam int BW = beat_width(DATA_BYTES);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_BYTES*8-1:0] data;
    logic [EW-1:0]           empty;
    logic                    sop;
    logic                    eop;
  } fifo_beat_t;

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, r_hwater;
  logic [31:0]   r_pkt_cnt, r_err_cnt, r_csr_rdata;
  logic          r_in_packet, r_csr_rdv;

  fifo_beat_t    w_wbeat, w_rbeat;
  logic [BW-1:0] w_rdata;
  logic [AW:0]   w_count_nxt;
  logic          w_full, w_empty, w_push, w_pop, w_frame_err, w_hw_clr;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // reset_n gating keeps ready low during reset yet lets the first edge after release push
  assign stream_in_ready  = reset_n & ~w_full;
  assign stream_out_valid = ~w_empty;
  assign csr_waitrequest  = ~reset_n;

  assign w_push = stream_in_valid & stream_in_ready;
  assign w_pop  = stream_out_valid & stream_out_ready;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_hw_clr = csr_write & ~csr_waitrequest & (csr_address == CSR_HIGHWATER);

  assign w_frame_err = w_push &
    ((stream_in_startofpacket & r_in_packet) |
     (stream_in_endofpacket & ~stream_in_startofpacket & ~r_in_packet));

  assign w_wbeat = '{data:  stream_in_data,
                     empty: stream_in_empty,
                     sop:   stream_in_startofpacket,
                     eop:   stream_in_endofpacket};
  assign w_rbeat = fifo_beat_t'(w_rdata);

  assign stream_out_data          = w_rbeat.data;
  assign stream_out_empty         = w_rbeat.empty;
  assign stream_out_startofpacket = w_rbeat.sop;
  assign stream_out_endofpacket   = w_rbeat.eop;

  sync_fifo_mem #(.WIDTH(BW), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (BW'(w_wbeat)),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_hwater    <= '0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_in_packet <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;

      // a clear in the same cycle as a new maximum wins, landing on post-update occupancy
      if (w_hw_clr)                     r_hwater <= w_count_nxt;
      else if (w_count_nxt > r_hwater)  r_hwater <= w_count_nxt;

      if (w_pop && w_rbeat.eop) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_frame_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 32'd1;

      if (w_push) begin
        if (stream_in_startofpacket)    r_in_packet <= ~stream_in_endofpacket;
        else if (stream_in_endofpacket) r_in_packet <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csr_rdv   <= 1'b0;
      r_csr_rdata <= '0;
    end else begin
      r_csr_rdv <= csr_read & ~csr_waitrequest;
      if (csr_read) begin
        case (csr_address)
          CSR_OCCUPANCY: r_csr_rdata <= 32'(r_count);
          CSR_HIGHWATER: r_csr_rdata <= 32'(r_hwater);
          CSR_PKT_COUNT: r_csr_rdata <= r_pkt_cnt;
          default:       r_csr_rdata <= r_err_cnt;
        endcase
      end
    end
  end

  assign csr_readdata      = r_csr_rdata;
  assign csr_readdatavalid = r_csr_rdv;

  logic w_unused;
  assign w_unused = ^csr_writedata;

endmodule
